// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM states, round constants, S-box and round-key storage types.
// Imported by the key expander, its interface and its SubWord helper.
package aes_pkg;

    localparam int AES_BLOCK_SIZE = 128;
    localparam int AES_ROUNDS     = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } key_state_e;

    typedef logic [AES_BLOCK_SIZE-1:0] round_key_t;
    typedef round_key_t round_key_array_t [0:AES_ROUNDS];

    // Entry 0 is unused so the table can be indexed directly by the round counter.
    localparam logic [7:0] RCON [0:AES_ROUNDS] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load handshake and round-key read port of the AES-128 key expander.
// The zeroize line exists only when AES_KEY_ZEROIZE_EN is defined.
interface aes_key_expander_if;
    import aes_pkg::*;

    logic        key_valid;
    logic        key_ready;
    round_key_t  key;
    logic        keys_valid;
    logic [3:0]  round_idx;
    round_key_t  round_key;
`ifdef AES_KEY_ZEROIZE_EN
    logic        zeroize;

    modport master (
        output key_valid, key, round_idx, zeroize,
        input  key_ready, keys_valid, round_key
    );

    modport slave (
        input  key_valid, key, round_idx, zeroize,
        output key_ready, keys_valid, round_key
    );
`else
    modport master (
        output key_valid, key, round_idx,
        input  key_ready, keys_valid, round_key
    );

    modport slave (
        input  key_valid, key, round_idx,
        output key_ready, keys_valid, round_key
    );
`endif

endinterface

// File: rtl/aes_key_sub_word.sv
// Combinational AES SubWord: the forward S-box applied to each byte of a 32-bit word.
module aes_key_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub[8*gi +: 8] = sbox(word[8*gi +: 8]);
        end
    endgenerate

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry store with a registered read port.
// Define AES_KEY_ZEROIZE_EN to add the zeroize input and clear the key store on reset or zeroize.
module aes_key_expander
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_key_expander_if.slave bus
);

    key_state_e       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    round_key_t       prev_reg, prev_next;
    round_key_t       round_key_reg;
    round_key_array_t rk_mem;

    logic             rk_we;
    logic [3:0]       rk_waddr;
    round_key_t       rk_wdata;
    logic             clear;

    logic [31:0]      w [4];
    logic [31:0]      nw0, nw1, nw2, nw3;
    logic [31:0]      sub;
    logic [31:0]      t;
    round_key_t       expanded;

`ifdef AES_KEY_ZEROIZE_EN
    assign clear = bus.zeroize;
`else
    assign clear = 1'b0;
`endif

    // w[0] is the most significant word, i.e. key bytes 0..3.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign w[gi] = prev_reg[AES_BLOCK_SIZE-1-32*gi -: 32];
        end
    endgenerate

    aes_key_sub_word u_sub_word (
        .word ({w[3][23:0], w[3][31:24]}),
        .sub  (sub)
    );

    assign t        = sub ^ {RCON[cnt_reg], 24'h0};
    assign nw0      = w[0] ^ t;
    assign nw1      = w[1] ^ nw0;
    assign nw2      = w[2] ^ nw1;
    assign nw3      = w[3] ^ nw2;
    assign expanded = {nw0, nw1, nw2, nw3};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        prev_next  = prev_reg;
        rk_we      = 1'b0;
        rk_waddr   = cnt_reg;
        rk_wdata   = expanded;
        case (state_reg)
            IDLE, READY: begin
                if (bus.key_valid) begin
                    state_next = EXPAND;
                    cnt_next   = 4'd1;
                    prev_next  = bus.key;
                    rk_we      = 1'b1;
                    rk_waddr   = 4'd0;
                    rk_wdata   = bus.key;
                end
            end
            EXPAND: begin
                rk_we     = 1'b1;
                prev_next = expanded;
                if (cnt_reg == 4'(AES_ROUNDS)) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset and zeroize win over any handshake or expansion step.
        if (rst || clear) begin
            rk_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            prev_reg  <= prev_next;
        end
    end

`ifdef AES_KEY_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i <= AES_ROUNDS; i++) begin
                rk_mem[i] <= '0;
            end
        end else if (rk_we) begin
            rk_mem[rk_waddr] <= rk_wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rk_we) begin
            rk_mem[rk_waddr] <= rk_wdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            round_key_reg <= '0;
        end else if (bus.round_idx <= 4'(AES_ROUNDS)) begin
            round_key_reg <= rk_mem[bus.round_idx];
        end else begin
            round_key_reg <= '0;
        end
    end

    assign bus.key_ready  = (state_reg != EXPAND);
    assign bus.keys_valid = (state_reg == READY);
    assign bus.round_key  = round_key_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors plus random keys against an algebraic key-schedule model.
// Covers the zeroize scenario when AES_KEY_ZEROIZE_EN is defined.
module tb_aes_key_expander;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;

    aes_key_expander_if bus ();

    aes_key_expander dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_A1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_A1   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_m   [0:255];
    logic [127:0] model_rk [0:10];

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v_in, input int n);
        logic [7:0] v;
        v = v_in;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic handshake(input logic [127:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic read_key(input logic [3:0] idx, output logic [127:0] v);
        bus.round_idx = idx;
        tick();
        v = bus.round_key;
    endtask

    task automatic wait_keys_valid(output int cycles);
        cycles = 0;
        while (bus.keys_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    // Read the whole set 10 -> 0, the order a decryption round controller uses.
    task automatic check_all(input string tag);
        logic [127:0] v;
        for (int r = 10; r >= 0; r--) begin
            read_key(4'(r), v);
            check($sformatf("%s_rk%0d", tag, r), v, model_rk[r]);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v;
        logic [127:0] k1;
        logic [127:0] k2;
        logic [3:0]   idx;
        int           cycles;

        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.round_idx = '0;
`ifdef AES_KEY_ZEROIZE_EN
        bus.zeroize   = 1'b0;
`endif
        build_sbox();
        tick();
        bus.key_valid = 1'b1;
        bus.key       = KEY_A1;
        tick();
        bus.key_valid = 1'b0;
        check_int("reset_key_ready", int'(bus.key_ready), 1);
        check_int("reset_keys_valid", int'(bus.keys_valid), 0);
        check("reset_round_key", bus.round_key, 128'h0);
        rst = 1'b0;
        tick();
        check_int("idle_key_ready", int'(bus.key_ready), 1);
        check_int("idle_keys_valid", int'(bus.keys_valid), 0);

        // FIPS-197 A.1 key
        model_expand(KEY_A1);
        handshake(KEY_A1);
        check_int("a1_key_ready_low", int'(bus.key_ready), 0);
        wait_keys_valid(cycles);
        check_int("a1_latency", cycles, 10);
        read_key(4'd1, v);
        check("a1_rk1", v, RK1_A1);
        read_key(4'd10, v);
        check("a1_rk10", v, RK10_A1);
        read_key(4'd0, v);
        check("a1_rk0_is_key", v, KEY_A1);
        read_key(4'd11, v);
        check("idx11_zero", v, 128'h0);
        read_key(4'd15, v);
        check("idx15_zero", v, 128'h0);
        check_all("a1");

        // Key_valid held through an expansion
        k1 = rand_key();
        k2 = rand_key();
        model_expand(k1);
        bus.round_idx = 4'd10;
        bus.key       = k1;
        bus.key_valid = 1'b1;
        tick();
        bus.key = k2;
        for (int i = 1; i <= 10; i++) begin
            check_int($sformatf("held_key_ready_c%0d", i), int'(bus.key_ready), 0);
            tick();
        end
        check_int("held_key_ready_back", int'(bus.key_ready), 1);
        check_int("held_keys_valid", int'(bus.keys_valid), 1);
        tick();
        check("held_first_rk10_intact", bus.round_key, model_rk[10]);
        check_int("held_second_accepted", int'(bus.key_ready), 0);
        bus.key_valid = 1'b0;
        model_expand(k2);
        wait_keys_valid(cycles);
        check_int("held_second_latency", cycles, 10);
        check_all("held_k2");

        // Reset in the middle of an expansion
        handshake(KEY_A1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_int("midrst_key_ready", int'(bus.key_ready), 1);
        check_int("midrst_keys_valid", int'(bus.keys_valid), 0);
        check("midrst_round_key", bus.round_key, 128'h0);
        repeat (3) tick();
        check_int("midrst_stays_idle", int'(bus.keys_valid), 0);
        model_expand(KEY_A1);
        handshake(KEY_A1);
        wait_keys_valid(cycles);
        check_int("midrst_reexpand_latency", cycles, 10);
        read_key(4'd10, v);
        check("midrst_reexpand_rk10", v, RK10_A1);

        // All-zero key loaded from READY
        model_expand(128'h0);
        handshake(128'h0);
        for (int i = 0; i < 10; i++) begin
            check_int($sformatf("zero_keys_valid_low_c%0d", i), int'(bus.keys_valid), 0);
            tick();
        end
        check_int("zero_keys_valid_high", int'(bus.keys_valid), 1);
        read_key(4'd10, v);
        check("zero_rk10", v, RK10_ZERO);
        check_all("zero");

        // Random keys and random read indices
        for (int n = 0; n < 4; n++) begin
            k1 = rand_key();
            model_expand(k1);
            handshake(k1);
            wait_keys_valid(cycles);
            check_int($sformatf("rand%0d_latency", n), cycles, 10);
            check_all($sformatf("rand%0d", n));
            for (int j = 0; j < 4; j++) begin
                idx = 4'($urandom_range(0, 15));
                read_key(idx, v);
                check($sformatf("rand%0d_idx%0d", n, idx), v, (idx <= 4'd10) ? model_rk[idx] : 128'h0);
            end
        end

`ifdef AES_KEY_ZEROIZE_EN
        // Zeroize mid-expansion together with a new handshake
        handshake(rand_key());
        repeat (2) tick();
        bus.zeroize   = 1'b1;
        bus.key       = rand_key();
        bus.key_valid = 1'b1;
        tick();
        bus.zeroize   = 1'b0;
        bus.key_valid = 1'b0;
        check_int("zeroize_key_ready", int'(bus.key_ready), 1);
        check_int("zeroize_keys_valid", int'(bus.keys_valid), 0);
        check("zeroize_round_key", bus.round_key, 128'h0);
        for (int r = 0; r <= 10; r++) begin
            read_key(4'(r), v);
            check($sformatf("zeroize_rk%0d", r), v, 128'h0);
        end
        check_int("zeroize_stays_idle", int'(bus.keys_valid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key-schedule engine that sits directly upstream of the round datapath. It accepts a 128-bit cipher key through a valid/ready handshake and expands it into 11 round keys at one round key per cycle, storing them in an internal register file. The round controller then reads any round key by index through a registered read port, so the same key set serves both encryption (index 0→10) and decryption (index 10→0) without re-expansion.

## Interface
- No parameters; the key size is fixed at 128 bits (`AES_BLOCK_SIZE`) and the round count is fixed at 10.
- Clk  input  1  the single clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Key_valid  input  1  Key is presented.
- Key_ready  output  1  block can accept a new key.
- Key  input  128  cipher key; Key[127:120] is key byte 0 (FIPS-197 order).
- Keys_valid  output  1  all 11 round keys are stored and stable.
- Round_idx  input  4  round key index to read, 0..10.
- Round_key  output  128  registered round key for the Round_idx sampled on the previous edge.
- Zeroize  input  1  present only with AES_KEY_ZEROIZE_EN (see Configuration).

## Operation
- FSM states: IDLE, EXPAND, READY.
- IDLE: Key_ready=1, Keys_valid=0. Handshake (Key_valid & Key_ready) → rk[0]<=Key, cnt<=1, prev<=Key, go to EXPAND.
- EXPAND: Key_ready=0, Keys_valid=0. Each cycle computes rk[cnt] from prev: t = SubWord(RotWord(w3)) ^ {Rcon[cnt],24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. Writes rk[cnt] and prev, then cnt++. The transition to READY occurs on the edge where cnt==10 is written.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- READY: Key_ready=1, Keys_valid=1. A new handshake behaves as in IDLE; Keys_valid falls on the next cycle. Key_valid is ignored while in EXPAND.
- Read port: every edge, Round_key <= (Round_idx<=10) ? rk[Round_idx] : 128'h0. Reads are always permitted. While Keys_valid=0, contents are unspecified and the consumer must gate on Keys_valid.
- The bit arithmetic is pure XOR and S-box. There are no carries, and cnt is a 4-bit counter that never exceeds 10.

## Timing
- Reset values: state=IDLE, Key_ready=1, Keys_valid=0, Round_key=0, cnt=0. The rk storage is not cleared, except under zeroize.
- Key latency: handshake on edge N → rk[i] valid after edge N+i (i=0..10). Keys_valid=1 in the cycle after edge N+10.
- Read latency: 1 cycle from Round_idx to Round_key.
- Rst mid-EXPAND aborts expansion. On the next edge the block is in IDLE with Keys_valid=0. Partially written keys remain in storage but are invalid.
- Rst together with Key_valid: Rst wins, and the key is not accepted.

## Configuration
- AES_KEY_ZEROIZE_EN defined:
  - The Zeroize port exists.
  - Zeroize=1 on an edge clears all rk, prev and Round_key to 0, forces IDLE and drops Keys_valid. It also aborts an expansion in progress and takes priority over a simultaneous handshake.
  - Rst additionally clears rk.
- AES_KEY_ZEROIZE_EN undefined: no Zeroize port, and rk has no reset.

## Structure
- Shared package aes_pkg holds:
  - the FSM state enum;
  - AES_ROUNDS=10 and the Rcon constant array;
  - the round-key array typedef (11 × `AES_BLOCK_SIZE`).
- One sub-module, aes_key_sub_word: combinational 32-bit SubWord built from four forward S-box instances.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, handshake at edge N:
  - Keys_valid rises after edge N+10.
  - Round_idx=1 → Round_key a0fafe1788542cb123a339392a6c7605.
  - Round_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key_valid held during EXPAND:
  - Key_ready stays 0 for cycles N+1..N+10.
  - The second key is accepted only at edge N+11 or later, and the first key set is intact until then.
- Round_idx=0 in READY → Round_key equals the input key. Round_idx=11 and 15 → 128'h0.
- Reset asserted at edge N+5:
  - IDLE on the following cycle, with Keys_valid=0 and Round_key=0.
  - Re-expanding the A.1 key then yields the correct rk[10].
- New key all zeros accepted in READY:
  - Keys_valid drops for 10 cycles.
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_KEY_ZEROIZE_EN:
  - Zeroize at edge N+3, coincident with Key_valid → all reads return 0, state IDLE, and the key is not accepted.
